// File: rtl/rdma_recv_if.sv
// Stream-in / AXI4-write-out bundle for the RDMA receive path.
// master is the receive engine's view, slave is the environment's.
interface rdma_recv_if #(
    parameter int DW = 512,
    parameter int AW = 64
) ();
    logic [AW-1:0]   AXIS_ADDR_TDATA;
    logic            AXIS_ADDR_TVALID;
    logic            AXIS_ADDR_TREADY;
    logic [DW-1:0]   AXIS_DATA_TDATA;
    logic            AXIS_DATA_TVALID;
    logic            AXIS_DATA_TLAST;
    logic            AXIS_DATA_TREADY;
    logic [AW-1:0]   M_AXI_AWADDR;
    logic [7:0]      M_AXI_AWLEN;
    logic [2:0]      M_AXI_AWSIZE;
    logic [1:0]      M_AXI_AWBURST;
    logic            M_AXI_AWID;
    logic            M_AXI_AWVALID;
    logic            M_AXI_AWREADY;
    logic [DW-1:0]   M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic            M_AXI_WLAST;
    logic            M_AXI_WVALID;
    logic            M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP;
    logic            M_AXI_BVALID;
    logic            M_AXI_BREADY;

    modport master (
        input  AXIS_ADDR_TDATA, AXIS_ADDR_TVALID,
        output AXIS_ADDR_TREADY,
        input  AXIS_DATA_TDATA, AXIS_DATA_TVALID, AXIS_DATA_TLAST,
        output AXIS_DATA_TREADY,
        output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE,
        output M_AXI_AWBURST, M_AXI_AWID, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY
    );

    modport slave (
        output AXIS_ADDR_TDATA, AXIS_ADDR_TVALID,
        input  AXIS_ADDR_TREADY,
        output AXIS_DATA_TDATA, AXIS_DATA_TVALID, AXIS_DATA_TLAST,
        input  AXIS_DATA_TREADY,
        input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE,
        input  M_AXI_AWBURST, M_AXI_AWID, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY
    );
endinterface

// File: rtl/rdma_recv.sv
// RDMA receive path: store-and-forward of addressed packets into
// AXI4 INCR write bursts, with B-response tracking and counters.
module rdma_recv #(
    parameter int AXI_DATA_WIDTH  = 512,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int MAX_BEATS       = 256,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clk,
    input  logic        reset,
    rdma_recv_if.master bus,
    output logic [31:0] bursts_done,
    output logic [31:0] bresp_errors,
    output logic        idle
);
    localparam int DW = AXI_DATA_WIDTH;
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int PW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(MAX_BEATS - 1);
    localparam logic [AW-1:0] STRIDE = AW'(MAX_BEATS * (DW / 8));
    localparam logic [15:0] MAX_OUT = 16'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_AW, S_W} state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   mem [MAX_BEATS];
    logic [AW-1:0]   cur_addr;
    logic [PW-1:0]   wcnt;
    logic [PW-1:0]   rptr;
    logic [7:0]      len;
    logic            more;
    logic [15:0]     outstanding;
    logic            run;
    logic            addr_rdy, data_rdy, awvalid, wvalid;
    logic            addr_hs, data_hs, aw_hs, w_hs;
    logic            wlast, wlast_hs, fill_end, b_hs;

    assign wlast    = (8'(rptr) == len);
    assign addr_hs  = addr_rdy && bus.AXIS_ADDR_TVALID;
    assign data_hs  = data_rdy && bus.AXIS_DATA_TVALID;
    assign aw_hs    = awvalid && bus.M_AXI_AWREADY;
    assign w_hs     = wvalid && bus.M_AXI_WREADY;
    assign wlast_hs = w_hs && wlast;
    assign b_hs     = run && bus.M_AXI_BVALID;
    assign fill_end = data_hs &&
                      (bus.AXIS_DATA_TLAST || wcnt == LAST_IDX);

    always_comb begin
        state_nx = state;
        addr_rdy = 1'b0;
        data_rdy = 1'b0;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        unique case (state)
            S_IDLE: begin
                addr_rdy = run && (outstanding < MAX_OUT);
                if (addr_rdy && bus.AXIS_ADDR_TVALID)
                    state_nx = S_FILL;
            end
            S_FILL: begin
                data_rdy = 1'b1;
                if (fill_end)
                    state_nx = S_AW;
            end
            S_AW: begin
                awvalid = 1'b1;
                if (bus.M_AXI_AWREADY)
                    state_nx = S_W;
            end
            S_W: begin
                wvalid = 1'b1;
                if (bus.M_AXI_WREADY && wlast)
                    state_nx = more ? S_FILL : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // buffer is not reset: contents are only read after being filled
    always_ff @(posedge clk) begin
        if (data_hs)
            mem[wcnt] <= bus.AXIS_DATA_TDATA;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run          <= 1'b0;
            cur_addr     <= '0;
            wcnt         <= '0;
            rptr         <= '0;
            len          <= '0;
            more         <= 1'b0;
            outstanding  <= '0;
            bursts_done  <= '0;
            bresp_errors <= '0;
        end else begin
            run <= 1'b1;
            if (addr_hs) begin
                cur_addr <= bus.AXIS_ADDR_TDATA;
                wcnt     <= '0;
            end
            if (data_hs)
                wcnt <= wcnt + 1'b1;
            if (fill_end) begin
                len  <= 8'(wcnt);
                more <= ~bus.AXIS_DATA_TLAST;
            end
            if (aw_hs)
                rptr <= '0;
            if (w_hs)
                rptr <= rptr + 1'b1;
            if (wlast_hs && more) begin
                cur_addr <= cur_addr + STRIDE;
                wcnt     <= '0;
            end
            // a stray B with nothing in flight must not underflow
            if (wlast_hs && !b_hs)
                outstanding <= outstanding + 1'b1;
            else if (!wlast_hs && b_hs && outstanding != '0)
                outstanding <= outstanding - 1'b1;
            if (b_hs) begin
                bursts_done <= bursts_done + 1'b1;
                if (bus.M_AXI_BRESP != 2'b00)
                    bresp_errors <= bresp_errors + 1'b1;
            end
        end
    end

    assign idle = (state == S_IDLE) && (outstanding == '0);

    assign bus.AXIS_ADDR_TREADY = addr_rdy;
    assign bus.AXIS_DATA_TREADY = data_rdy;
    assign bus.M_AXI_AWADDR     = cur_addr;
    assign bus.M_AXI_AWLEN      = len;
    assign bus.M_AXI_AWSIZE     = 3'($clog2(DW / 8));
    assign bus.M_AXI_AWBURST    = 2'b01;
    assign bus.M_AXI_AWID       = 1'b0;
    assign bus.M_AXI_AWVALID    = awvalid;
    assign bus.M_AXI_WDATA      = mem[rptr];
    assign bus.M_AXI_WSTRB      = '1;
    assign bus.M_AXI_WLAST      = wlast;
    assign bus.M_AXI_WVALID     = wvalid;
    assign bus.M_AXI_BREADY     = run;
endmodule

// File: tb/tb_rdma_recv.sv
// Bench for rdma_recv: directed scenarios plus randomized packets,
// checked against a packet-splitting model and a B-response scoreboard.
module tb_rdma_recv;
    localparam int DW   = 512;
    localparam int AW   = 64;
    localparam int MB   = 256;
    localparam int MO   = 2;
    localparam int TMO  = 3000;
    localparam logic [AW-1:0] STRIDE = AW'(MB * (DW / 8));

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bursts_done;
    logic [31:0] bresp_errors;
    logic        idle;

    rdma_recv_if #(.DW(DW), .AW(AW)) bus ();

    rdma_recv #(
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW),
        .MAX_BEATS(MB),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .bursts_done(bursts_done),
        .bresp_errors(bresp_errors),
        .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // expected traffic
    logic [AW-1:0] exp_aw_addr [$];
    logic [7:0]    exp_aw_len  [$];
    logic [DW-1:0] exp_w_data  [$];
    logic          exp_w_last  [$];
    logic [1:0]    resp_q      [$];

    int w_done  = 0;
    int w_beats = 0;
    int b_sent  = 0;
    int exp_done = 0;
    int exp_err  = 0;
    bit b_en   = 1'b1;
    bit b_rand = 1'b0;
    int aw_mode = 0;
    int w_mode  = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++)
            w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // a packet becomes ceil(n/MB) bursts, each MB*64 bytes apart
    task automatic model_pkt(input logic [AW-1:0] addr,
                             input logic [DW-1:0] d [$]);
        int rem = d.size();
        int idx = 0;
        logic [AW-1:0] a = addr;
        while (rem > 0) begin
            int chunk = (rem > MB) ? MB : rem;
            exp_aw_addr.push_back(a);
            exp_aw_len.push_back(8'(chunk - 1));
            for (int j = 0; j < chunk; j++) begin
                exp_w_data.push_back(d[idx + j]);
                exp_w_last.push_back(j == chunk - 1);
            end
            a   = a + STRIDE;
            rem = rem - chunk;
            idx = idx + chunk;
        end
    endtask

    task automatic send_pkt(input logic [AW-1:0] addr, input int n,
                            input bit gaps);
        logic [DW-1:0] d [$];
        bit ok, hs;
        for (int i = 0; i < n; i++)
            d.push_back(rnd_word());
        model_pkt(addr, d);
        bus.AXIS_ADDR_TDATA  = addr;
        bus.AXIS_ADDR_TVALID = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            hs = bus.AXIS_ADDR_TREADY;
            @(posedge clk); #1;
            if (hs) begin ok = 1'b1; break; end
        end
        bus.AXIS_ADDR_TVALID = 1'b0;
        chk("addr_accept", ok, 1);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.AXIS_DATA_TVALID = 1'b0;
                @(posedge clk); #1;
            end
            bus.AXIS_DATA_TDATA  = d[i];
            bus.AXIS_DATA_TLAST  = (i == n - 1);
            bus.AXIS_DATA_TVALID = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < TMO; c++) begin
                @(negedge clk);
                hs = bus.AXIS_DATA_TREADY;
                @(posedge clk); #1;
                if (hs) begin ok = 1'b1; break; end
            end
            if (!ok) chk("data_accept", ok, 1);
        end
        bus.AXIS_DATA_TVALID = 1'b0;
        bus.AXIS_DATA_TLAST  = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (exp_aw_addr.size() == 0 && exp_w_data.size() == 0 &&
                b_sent == w_done && !bus.M_AXI_BVALID &&
                !bus.M_AXI_AWVALID && !bus.M_AXI_WVALID) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_drain"}, ok, 1);
        @(negedge clk);
        chk({tag, "_bursts_done"}, bursts_done, exp_done);
        chk({tag, "_bresp_errors"}, bresp_errors, exp_err);
        chk({tag, "_idle"}, idle, 1);
    endtask

    // monitor: compares AW/W handshakes to the model, checks holds
    int aw_open = 0;
    bit aw_stall = 0, w_stall = 0;
    logic [AW-1:0] aw_prev_addr;
    logic [7:0]    aw_prev_len;
    logic [DW-1:0] w_prev_data;
    logic          w_prev_last;
    always @(negedge clk) begin
        if (reset) begin
            exp_aw_addr.delete();
            exp_aw_len.delete();
            exp_w_data.delete();
            exp_w_last.delete();
            w_done = 0; w_beats = 0; aw_open = 0;
            aw_stall = 0; w_stall = 0;
        end else begin
            if (aw_stall) begin
                chk("aw_hold_valid", bus.M_AXI_AWVALID, 1);
                chk("aw_hold_addr", bus.M_AXI_AWADDR, aw_prev_addr);
                chk("aw_hold_len", bus.M_AXI_AWLEN, aw_prev_len);
            end
            if (w_stall) begin
                chk("w_hold_valid", bus.M_AXI_WVALID, 1);
                chk("w_hold_data", bus.M_AXI_WDATA, w_prev_data);
                chk("w_hold_last", bus.M_AXI_WLAST, w_prev_last);
            end
            if (bus.M_AXI_WVALID)
                chk("w_after_aw", aw_open > 0, 1);
            if (bus.M_AXI_AWVALID || bus.M_AXI_WVALID)
                chk("busy_not_idle", idle, 0);
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
                chk("w_expected", exp_w_data.size() != 0, 1);
                chk("wstrb", bus.M_AXI_WSTRB, {(DW/8){1'b1}});
                if (exp_w_data.size() != 0) begin
                    chk("wdata", bus.M_AXI_WDATA, exp_w_data.pop_front());
                    chk("wlast", bus.M_AXI_WLAST, exp_w_last.pop_front());
                end
                w_beats++;
                if (bus.M_AXI_WLAST) begin
                    w_done++;
                    aw_open--;
                end
            end
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
                chk("aw_expected", exp_aw_addr.size() != 0, 1);
                chk("awsize", bus.M_AXI_AWSIZE, 6);
                chk("awburst", bus.M_AXI_AWBURST, 1);
                if (exp_aw_addr.size() != 0) begin
                    chk("awaddr", bus.M_AXI_AWADDR, exp_aw_addr.pop_front());
                    chk("awlen", bus.M_AXI_AWLEN, exp_aw_len.pop_front());
                end
                aw_open++;
            end
            aw_stall     = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
            aw_prev_addr = bus.M_AXI_AWADDR;
            aw_prev_len  = bus.M_AXI_AWLEN;
            w_stall      = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
            w_prev_data  = bus.M_AXI_WDATA;
            w_prev_last  = bus.M_AXI_WLAST;
        end
    end

    // slave side: AWREADY/WREADY patterns and B responses
    initial begin
        logic [1:0] r;
        bus.M_AXI_AWREADY = 1'b1;
        bus.M_AXI_WREADY  = 1'b1;
        bus.M_AXI_BVALID  = 1'b0;
        bus.M_AXI_BRESP   = 2'b00;
        forever begin
            @(posedge clk); #1;
            bus.M_AXI_AWREADY = (aw_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            case (w_mode)
                0: bus.M_AXI_WREADY = 1'b1;
                1: bus.M_AXI_WREADY = ~bus.M_AXI_WREADY;
                default: bus.M_AXI_WREADY = 1'($urandom_range(0, 1));
            endcase
            bus.M_AXI_BVALID = 1'b0;
            bus.M_AXI_BRESP  = 2'b00;
            if (reset) begin
                b_sent = 0; exp_done = 0; exp_err = 0;
                resp_q.delete();
            end else if (b_en && b_sent < w_done &&
                         !(b_rand && $urandom_range(0, 2) == 0)) begin
                if (resp_q.size() != 0)
                    r = resp_q.pop_front();
                else if (b_rand && $urandom_range(0, 3) == 0)
                    r = 2'($urandom_range(1, 3));
                else
                    r = 2'b00;
                bus.M_AXI_BVALID = 1'b1;
                bus.M_AXI_BRESP  = r;
                b_sent++;
                exp_done++;
                if (r != 2'b00) exp_err++;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0, wd0, wb0, nrdy, naw;
        bit ok;
        logic [AW-1:0] a;
        bus.AXIS_ADDR_TDATA  = '0;
        bus.AXIS_ADDR_TVALID = 1'b0;
        bus.AXIS_DATA_TDATA  = '0;
        bus.AXIS_DATA_TVALID = 1'b0;
        bus.AXIS_DATA_TLAST  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awvalid", bus.M_AXI_AWVALID, 0);
        chk("rst_wvalid", bus.M_AXI_WVALID, 0);
        chk("rst_addr_tready", bus.AXIS_ADDR_TREADY, 0);
        chk("rst_data_tready", bus.AXIS_DATA_TREADY, 0);
        chk("rst_bready", bus.M_AXI_BREADY, 0);
        chk("rst_bursts_done", bursts_done, 0);
        chk("rst_bresp_errors", bresp_errors, 0);
        chk("rst_idle", idle, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_bready", bus.M_AXI_BREADY, 1);
        chk("post_rst_addr_tready", bus.AXIS_ADDR_TREADY, 1);
        chk("post_rst_data_tready", bus.AXIS_DATA_TREADY, 0);
        @(posedge clk); #1;

        // single beat
        send_pkt(64'h1000, 1, 1'b0);
        @(negedge clk);
        chk("t1_aw_latency", bus.M_AXI_AWVALID, 1);
        drain("t1");
        chk("t1_count", bursts_done, 1);
        @(posedge clk); #1;

        // four beats with WREADY toggling
        w_mode = 1;
        send_pkt(64'h2000, 4, 1'b0);
        @(negedge clk);
        chk("t2_aw_latency", bus.M_AXI_AWVALID, 1);
        drain("t2");
        w_mode = 0;
        @(posedge clk); #1;

        // 300 beats split into 256 + 44
        d0 = exp_done;
        send_pkt(64'h0, 300, 1'b0);
        drain("t3");
        chk("t3_two_bursts", bursts_done, d0 + 2);
        @(posedge clk); #1;

        // second burst gets SLVERR
        d0 = exp_done;
        e0 = exp_err;
        resp_q.push_back(2'b00);
        resp_q.push_back(2'b10);
        send_pkt(64'h3000, 2, 1'b0);
        send_pkt(64'h3100, 3, 1'b0);
        drain("t4");
        chk("t4_done", bursts_done, d0 + 2);
        chk("t4_err", bresp_errors, e0 + 1);
        @(posedge clk); #1;

        // outstanding limit blocks the third packet
        b_en = 1'b0;
        wd0 = w_done;
        send_pkt(64'h5000, 3, 1'b0);
        send_pkt(64'h6000, 2, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            @(posedge clk); #1;
            if (w_done == wd0 + 2) begin ok = 1'b1; break; end
        end
        chk("t5_two_issued", ok, 1);
        bus.AXIS_ADDR_TDATA  = 64'h7000;
        bus.AXIS_ADDR_TVALID = 1'b1;
        nrdy = 0;
        naw  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.AXIS_ADDR_TREADY) nrdy++;
            if (bus.M_AXI_AWVALID) naw++;
        end
        chk("t5_addr_blocked", nrdy, 0);
        chk("t5_aw_blocked", naw, 0);
        chk("t5_issued_count", w_done - wd0, 2);
        @(posedge clk); #1;
        b_en = 1'b1;
        send_pkt(64'h7000, 2, 1'b0);
        drain("t5");
        @(posedge clk); #1;

        // reset in the middle of a burst
        b_en = 1'b0;
        wb0 = w_beats;
        send_pkt(64'h8000, 4, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            @(posedge clk); #1;
            if (w_beats == wb0 + 2) begin ok = 1'b1; break; end
        end
        chk("t6_reach_beat2", ok, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_awvalid", bus.M_AXI_AWVALID, 0);
        chk("t6_wvalid", bus.M_AXI_WVALID, 0);
        chk("t6_bursts_done", bursts_done, 0);
        chk("t6_bresp_errors", bresp_errors, 0);
        chk("t6_idle", idle, 1);
        chk("t6_data_tready", bus.AXIS_DATA_TREADY, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        b_en  = 1'b1;
        @(posedge clk); #1;
        send_pkt(64'h9000, 3, 1'b0);
        drain("t6");
        chk("t6_count", bursts_done, 1);
        @(posedge clk); #1;

        // randomized packets, ready patterns and responses
        aw_mode = 1;
        w_mode  = 2;
        b_rand  = 1'b1;
        for (int p = 0; p < 14; p++) begin
            a = {32'h0, $urandom} & 64'hFFFF_FFFF_FFFF_FFC0;
            if (p == 7)
                send_pkt(a, $urandom_range(257, 280), 1'b1);
            else
                send_pkt(a, $urandom_range(1, 40), 1'b1);
        end
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
